// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: a small register window on the CPU
// data bus, a byte FIFO, and a start/data/stop serialiser on one output pin.
`timescale 1ns/1ps

module uart_tx_mmio #(
   parameter logic [23:0] BASE_ADDR  = 24'hFFFF00,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_en,
   input  logic [23:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_wr,
   input  logic        i_rd,
   output logic        o_hit,
   output logic [31:0] o_rdata,
   output logic        o_txd,
   output logic        o_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_next;
   logic [BW-1:0] baud, baud_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    shift, shift_next;
   logic          txd_next;
   logic          pop;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic          overflow;
   logic          enable;

   logic [23:0]   offset;
   logic [1:0]    reg_sel;
   logic          access, push_req, push_ok, overflow_set, ctrl_wr, status_rd;
   logic          full, empty, can_pop, baud_done, busy_next;
   logic [31:0]   count_wide, status_word, read_mux;
   logic          unused_bits;

   // Address decode: the window is the four words starting at BASE_ADDR.
   assign offset  = i_addr - BASE_ADDR;
   assign o_hit   = (offset < 24'd4);
   assign reg_sel = offset[1:0];

   assign access       = i_clk_en & o_hit;
   assign push_req     = access & i_wr & (reg_sel == 2'd0);
   assign ctrl_wr      = access & i_wr & (reg_sel == 2'd2);
   assign status_rd    = access & i_rd & (reg_sel == 2'd1);

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign can_pop      = enable & ~empty;
   assign baud_done    = (baud == BAUD_LAST);
   assign push_ok      = push_req & (~full | pop);
   assign overflow_set = push_req & full & ~pop;

   assign count_wide   = 32'(count);
   assign status_word  = {24'b0, count_wide[3:0], overflow, (state != IDLE), empty, full};
   assign unused_bits  = ^{i_wdata[31:8], count_wide[31:4]};

   // Register read multiplexer; DATA and the spare slot read as zero.
   always_comb begin
      read_mux = 32'b0;
      case (reg_sel)
         2'd1:    read_mux = status_word;
         2'd2:    read_mux = {31'b0, enable};
         default: read_mux = 32'b0;
      endcase
   end

   // Serialiser next-state logic; a pop loads the shift register and drops into the start bit.
   always_comb begin
      state_next   = state;
      baud_next    = baud;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      txd_next     = o_txd;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (can_pop) begin
               pop          = 1'b1;
               shift_next   = mem[rd_ptr];
               bit_cnt_next = 3'd0;
               baud_next    = '0;
               state_next   = START;
               txd_next     = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = DATA;
               txd_next   = shift[0];
            end else begin
               baud_next = baud + BW'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next    = '0;
               shift_next   = shift >> 1;
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  txd_next = shift[1];
               end
            end else begin
               baud_next = baud + BW'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               if (can_pop) begin
                  pop          = 1'b1;
                  shift_next   = mem[rd_ptr];
                  bit_cnt_next = 3'd0;
                  state_next   = START;
                  txd_next     = 1'b0;
               end else begin
                  state_next = IDLE;
                  txd_next   = 1'b1;
               end
            end else begin
               baud_next = baud + BW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   // FIFO occupancy after this edge's push and pop, and the busy flag it implies.
   always_comb begin
      count_next = count;
      case ({push_ok, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
      busy_next = (state_next != IDLE) || (count_next != '0);
   end

   // Serialiser state register; reset aborts any frame and returns the line to idle-high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
         o_txd   <= 1'b1;
      end else if (i_clk_en) begin
         state   <= state_next;
         baud    <= baud_next;
         bit_cnt <= bit_cnt_next;
         shift   <= shift_next;
         o_txd   <= txd_next;
      end
   end

   // FIFO pointers, sticky overflow, control bit, read data and busy flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         enable   <= 1'b1;
         o_rdata  <= 32'b0;
         o_busy   <= 1'b0;
      end else if (i_clk_en) begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         count  <= count_next;
         o_busy <= busy_next;
         if (overflow_set)   overflow <= 1'b1;
         else if (status_rd) overflow <= 1'b0;
         if (ctrl_wr) enable <= i_wdata[0];
         if (o_hit && i_rd) o_rdata <= read_mux;
      end
   end

   // FIFO storage; entries need no reset because the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (!i_rst && push_ok) mem[wr_ptr] <= i_wdata[7:0];
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame shape, overflow,
// back-to-back frames, reset abort and clock-enable stretching.
`timescale 1ns/1ps

module tb_uart_tx_mmio;

   localparam logic [23:0] BASE = 24'hFFFF00;
   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic [23:0] addr;
   logic [31:0] wdata;
   logic        wr, rd;
   logic        hit;
   logic [31:0] rdata;
   logic        txd;
   logic        busy;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [7:0] bytes [9] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A};
   logic       high_all;
   logic [7:0] cur_byte;

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_addr(addr), .i_wdata(wdata),
      .i_wr(wr), .i_rd(rd), .o_hit(hit), .o_rdata(rdata), .o_txd(txd), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Bit k of the 10-bit 8N1 frame for byte b: start 0, data LSB first, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      return f[k[3:0]];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, input logic w, input logic r);
      addr  = a;
      wdata = d;
      wr    = w;
      rd    = r;
      tick();
      wr    = 1'b0;
      rd    = 1'b0;
      addr  = 24'h0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired after %0d/%0d checks", passes, checks);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b1; clk_en = 1'b1; addr = 24'h0; wdata = 32'h0; wr = 1'b0; rd = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset values and address decode
      checkOutput("rst_txd", 32'(txd), 32'h1);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      addr = BASE;             #1 checkOutput("hit_base", 32'(hit), 32'h1);
      addr = 24'(BASE + 3);    #1 checkOutput("hit_top", 32'(hit), 32'h1);
      addr = 24'(BASE + 4);    #1 checkOutput("hit_above", 32'(hit), 32'h0);
      addr = 24'(BASE - 1);    #1 checkOutput("hit_below", 32'(hit), 32'h0);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("rst_status", rdata, 32'h0000_0002);
      applyStimulus(24'(BASE + 2), 32'h0, 1'b0, 1'b1);
      checkOutput("rst_ctrl", rdata, 32'h0000_0001);
      applyStimulus(24'(BASE + 3), 32'h0, 1'b0, 1'b1);
      checkOutput("spare_read", rdata, 32'h0);
      applyStimulus(24'(BASE + 4), 32'h77, 1'b1, 1'b0);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("miss_write_status", rdata, 32'h0000_0002);
      checkOutput("miss_write_busy", 32'(busy), 32'h0);

      // Single byte 0xA5: line shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit
      applyStimulus(BASE, 32'hA5, 1'b1, 1'b0);
      checkOutput("single_busy_rise", 32'(busy), 32'h1);
      checkOutput("single_pre_start", 32'(txd), 32'h1);
      for (int i = 0; i < 40; i++) begin
         tick();
         checkOutput($sformatf("single_bit%0d_cyc%0d", i / CLK_DIV, i), 32'(txd), 32'(frame_bit(8'hA5, i / CLK_DIV)));
         if (i == 39) checkOutput("single_busy_last", 32'(busy), 32'h1);
      end
      tick();
      checkOutput("single_busy_fall", 32'(busy), 32'h0);
      checkOutput("single_idle_txd", 32'(txd), 32'h1);

      // Overflow with transmission disabled
      applyStimulus(24'(BASE + 2), 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) applyStimulus(BASE, {24'h0, bytes[k]}, 1'b1, 1'b0);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("ovf_status", rdata, 32'h0000_0089);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("ovf_cleared", rdata, 32'h0000_0081);
      checkOutput("ovf_disabled_txd", 32'(txd), 32'h1);
      checkOutput("ovf_busy", 32'(busy), 32'h1);
      applyStimulus(BASE, 32'h0, 1'b0, 1'b1);
      checkOutput("data_read_zero", rdata, 32'h0);
      applyStimulus(24'(BASE + 2), 32'h1, 1'b1, 1'b0);
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput($sformatf("ovf_frame%0d_cyc%0d", f, i), 32'(txd), 32'(frame_bit(bytes[f], i / CLK_DIV)));
         end
      end
      tick();
      checkOutput("ovf_done_busy", 32'(busy), 32'h0);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("ovf_done_status", rdata, 32'h0000_0002);

      // Back-to-back 0x00 then 0xFF: no gap between frames
      applyStimulus(BASE, 32'h00, 1'b1, 1'b0);
      applyStimulus(BASE, 32'hFF, 1'b1, 1'b0);
      checkOutput("b2b_cyc0", 32'(txd), 32'h0);
      for (int i = 1; i < 80; i++) begin
         tick();
         cur_byte = (i < 40) ? 8'h00 : 8'hFF;
         checkOutput($sformatf("b2b_cyc%0d", i), 32'(txd), 32'(frame_bit(cur_byte, (i % 40) / CLK_DIV)));
      end
      tick();
      checkOutput("b2b_busy_fall", 32'(busy), 32'h0);

      // Reset during data bit 3 of 0x0F
      applyStimulus(BASE, 32'h0F, 1'b1, 1'b0);
      repeat (18) tick();
      checkOutput("abort_bit3", 32'(txd), 32'h1);
      checkOutput("abort_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_txd", 32'(txd), 32'h1);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      applyStimulus(24'(BASE + 1), 32'h0, 1'b0, 1'b1);
      checkOutput("abort_status", rdata, 32'h0000_0002);
      high_all = 1'b1;
      repeat (50) begin
         tick();
         if (txd !== 1'b1) high_all = 1'b0;
      end
      checkOutput("abort_line_quiet", 32'(high_all), 32'h1);

      // Clock enable at 50%: every bit lasts 8 clocks
      applyStimulus(BASE, 32'hA5, 1'b1, 1'b0);
      clk_en = 1'b0;
      tick();
      checkOutput("cke_hold_idle", 32'(txd), 32'h1);
      clk_en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         checkOutput($sformatf("cke_bit%0d_cyc%0d", i / 8, i), 32'(txd), 32'(frame_bit(8'hA5, i / 8)));
         clk_en = ~clk_en;
      end
      clk_en = 1'b1;
      tick();
      checkOutput("cke_busy_fall", 32'(busy), 32'h0);
      checkOutput("cke_idle_txd", 32'(txd), 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
